// File: rtl/vm_pkg.sv
// vm_pkg: shared state/coin types and coin value constants for vm_ctrl.
package vm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        VEND    = 2'd2,
        CHANGE  = 2'd3
    } vm_state_t;

    typedef enum logic [1:0] {
        COIN_10  = 2'd0,
        COIN_20  = 2'd1,
        COIN_50  = 2'd2,
        COIN_100 = 2'd3
    } coin_t;

    localparam int unsigned COIN_VAL_10  = 10;
    localparam int unsigned COIN_VAL_20  = 20;
    localparam int unsigned COIN_VAL_50  = 50;
    localparam int unsigned COIN_VAL_100 = 100;

endpackage

// File: rtl/vm_change_sel.sv
// vm_change_sel: combinational pick of the largest coin not exceeding an amount.
module vm_change_sel
    import vm_pkg::*;
#(
    parameter int unsigned CREDIT_W = 8
) (
    input  logic [CREDIT_W-1:0] amount,
    output coin_t               coin
);

    localparam logic [CREDIT_W-1:0] V20  = CREDIT_W'(COIN_VAL_20);
    localparam logic [CREDIT_W-1:0] V50  = CREDIT_W'(COIN_VAL_50);
    localparam logic [CREDIT_W-1:0] V100 = CREDIT_W'(COIN_VAL_100);

    // Largest coin <= amount; anything below 20 maps to the 10 coin.
    always_comb begin
        coin = COIN_10;
        if (amount >= V100) begin
            coin = COIN_100;
        end else if (amount >= V50) begin
            coin = COIN_50;
        end else if (amount >= V20) begin
            coin = COIN_20;
        end
    end

endmodule

// File: rtl/vm_ctrl.sv
// vm_ctrl: vending machine controller (coin credit, product vend, change payout).
// Optional feature: define VM_CTRL_TIMEOUT_EN to refund credit after
// TIMEOUT_CYC strobe-free cycles in COLLECT.
module vm_ctrl
    import vm_pkg::*;
#(
    parameter int unsigned                  CREDIT_W    = 8,
    parameter int unsigned                  NUM_PROD    = 4,
    parameter logic [NUM_PROD*CREDIT_W-1:0] PRICES      = {8'd120, 8'd90, 8'd70, 8'd50},
    parameter int unsigned                  TIMEOUT_CYC = 1000,
    localparam int unsigned                 ID_W        = (NUM_PROD > 1) ? $clog2(NUM_PROD) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                coin_valid,
    input  logic [1:0]          coin_type,
    output logic                coin_reject,
    input  logic                sel_valid,
    input  logic [ID_W-1:0]     sel_id,
    input  logic                cancel,
    output logic                vend_valid,
    output logic [ID_W-1:0]     vend_id,
    input  logic                vend_ready,
    output logic                change_valid,
    output logic [1:0]          change_coin,
    input  logic                change_ready,
    output logic [CREDIT_W-1:0] credit,
    output logic                short_pulse
);

    vm_state_t           state, state_nxt;
    logic [CREDIT_W-1:0] credit_nxt;
    logic [ID_W-1:0]     vend_id_nxt;
    logic                coin_reject_nxt, short_nxt;
    logic                enter_change;
    logic [CREDIT_W-1:0] change_amt;
    logic [CREDIT_W:0]   coin_sum;
    logic                coin_fits, sel_ok;
    logic [CREDIT_W-1:0] sel_price, vend_price;
    coin_t               chg_coin, chg_coin_sel;

    function automatic logic [CREDIT_W-1:0] coin_amt(input coin_t c);
        case (c)
            COIN_10:  return CREDIT_W'(COIN_VAL_10);
            COIN_20:  return CREDIT_W'(COIN_VAL_20);
            COIN_50:  return CREDIT_W'(COIN_VAL_50);
            default:  return CREDIT_W'(COIN_VAL_100);
        endcase
    endfunction

    // Sub-10 residue cannot be paid out, so it is dropped on entry to CHANGE.
    function automatic logic [CREDIT_W-1:0] round_down10(input logic [CREDIT_W-1:0] a);
        return a - (a % CREDIT_W'(10));
    endfunction

    assign sel_ok      = ({1'b0, sel_id} < (ID_W+1)'(NUM_PROD));
    assign sel_price   = PRICES[int'(sel_id)*CREDIT_W +: CREDIT_W];
    assign vend_price  = PRICES[int'(vend_id)*CREDIT_W +: CREDIT_W];
    assign change_coin = chg_coin;

`ifdef VM_CTRL_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] idle_cnt;
    logic             timeout_hit;

    assign timeout_hit = (idle_cnt == CNT_W'(TIMEOUT_CYC - 1));

    // Count strobe-free COLLECT cycles; any strobe or state exit clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (state == COLLECT && state_nxt == COLLECT &&
                     !(coin_valid || sel_valid || cancel)) begin
            idle_cnt <= idle_cnt + CNT_W'(1);
        end else begin
            idle_cnt <= '0;
        end
    end
`else
    logic [31:0] unused_timeout_cfg;
    assign unused_timeout_cfg = TIMEOUT_CYC;
`endif

    vm_change_sel #(.CREDIT_W(CREDIT_W)) u_change_sel (
        .amount (credit_nxt),
        .coin   (chg_coin_sel)
    );

    // Next-state, next-credit and strobe responses; cancel beats select,
    // and a select that vends rejects a coin arriving in the same cycle.
    always_comb begin
        state_nxt       = state;
        credit_nxt      = credit;
        vend_id_nxt     = vend_id;
        coin_reject_nxt = 1'b0;
        short_nxt       = 1'b0;
        enter_change    = 1'b0;
        change_amt      = credit;
        coin_sum        = {1'b0, credit} + {1'b0, coin_amt(coin_t'(coin_type))};
        coin_fits       = ~coin_sum[CREDIT_W];
        case (state)
            IDLE, COLLECT: begin
                if (cancel && state == COLLECT) begin
                    enter_change = 1'b1;
                    if (coin_valid && coin_fits) begin
                        change_amt = coin_sum[CREDIT_W-1:0];
                    end else begin
                        coin_reject_nxt = coin_valid;
                    end
                end else if (sel_valid && sel_ok && credit >= sel_price) begin
                    state_nxt       = VEND;
                    vend_id_nxt     = sel_id;
                    coin_reject_nxt = coin_valid;
                end else begin
                    short_nxt = sel_valid && sel_ok;
                    if (coin_valid) begin
                        if (coin_fits) begin
                            credit_nxt = coin_sum[CREDIT_W-1:0];
                            state_nxt  = COLLECT;
                        end else begin
                            coin_reject_nxt = 1'b1;
                        end
                    end
`ifdef VM_CTRL_TIMEOUT_EN
                    else if (state == COLLECT && !sel_valid && timeout_hit) begin
                        enter_change = 1'b1;
                    end
`endif
                end
            end
            VEND: begin
                coin_reject_nxt = coin_valid;
                if (vend_ready) begin
                    enter_change = 1'b1;
                    change_amt   = credit - vend_price;
                end
            end
            CHANGE: begin
                coin_reject_nxt = coin_valid;
                if (change_ready) begin
                    credit_nxt = credit - coin_amt(chg_coin);
                    if (credit_nxt == '0) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (enter_change) begin
            credit_nxt = round_down10(change_amt);
            state_nxt  = (credit_nxt == '0) ? IDLE : CHANGE;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            credit       <= '0;
            vend_id      <= '0;
            vend_valid   <= 1'b0;
            change_valid <= 1'b0;
            chg_coin     <= COIN_10;
            coin_reject  <= 1'b0;
            short_pulse  <= 1'b0;
        end else begin
            state        <= state_nxt;
            credit       <= credit_nxt;
            vend_id      <= vend_id_nxt;
            vend_valid   <= (state_nxt == VEND);
            change_valid <= (state_nxt == CHANGE);
            chg_coin     <= (state_nxt == CHANGE) ? chg_coin_sel : COIN_10;
            coin_reject  <= coin_reject_nxt;
            short_pulse  <= short_nxt;
        end
    end

endmodule

// File: tb/tb_vm_ctrl.sv
// tb_vm_ctrl: directed table-driven bench for vm_ctrl.
// Prices overridden so product 0..3 cost 120/90/70/50.
module tb_vm_ctrl;

    localparam int unsigned TO = 40;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       coin_valid, sel_valid, cancel, vend_ready, change_ready;
    logic [1:0] coin_type, sel_id;
    logic       coin_reject, vend_valid, change_valid, short_pulse;
    logic [1:0] vend_id, change_coin;
    logic [7:0] credit;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    vm_ctrl #(
        .CREDIT_W    (8),
        .NUM_PROD    (4),
        .PRICES      ({8'd50, 8'd70, 8'd90, 8'd120}),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .coin_valid   (coin_valid),
        .coin_type    (coin_type),
        .coin_reject  (coin_reject),
        .sel_valid    (sel_valid),
        .sel_id       (sel_id),
        .cancel       (cancel),
        .vend_valid   (vend_valid),
        .vend_id      (vend_id),
        .vend_ready   (vend_ready),
        .change_valid (change_valid),
        .change_coin  (change_coin),
        .change_ready (change_ready),
        .credit       (credit),
        .short_pulse  (short_pulse)
    );

    typedef struct {
        logic       in_cv;
        logic [1:0] in_ct;
        logic       in_sv;
        logic [1:0] in_sid;
        logic       in_can;
        logic       in_vr;
        logic       in_cr;
        logic [7:0] ex_credit;
        logic       ex_rej;
        logic       ex_sp;
        logic       ex_vv;
        logic [1:0] ex_vid;
        logic       ex_chv;
        logic [1:0] ex_chc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic cv, input logic [1:0] ct, input logic sv,
                                input logic [1:0] sid, input logic can, input logic vr,
                                input logic cr, input logic [7:0] cred, input logic rej,
                                input logic sp, input logic vv, input logic [1:0] vid,
                                input logic chv, input logic [1:0] chc);
        vec_t v;
        v.in_cv = cv; v.in_ct = ct; v.in_sv = sv; v.in_sid = sid; v.in_can = can;
        v.in_vr = vr; v.in_cr = cr;
        v.ex_credit = cred; v.ex_rej = rej; v.ex_sp = sp; v.ex_vv = vv;
        v.ex_vid = vid; v.ex_chv = chv; v.ex_chc = chc;
        return v;
    endfunction

    function automatic logic [15:0] exp_of(input vec_t v);
        return {v.ex_credit, v.ex_rej, v.ex_sp, v.ex_vv, v.ex_vid, v.ex_chv, v.ex_chc};
    endfunction

    function logic [15:0] act_of();
        return {credit, coin_reject, short_pulse, vend_valid, vend_id, change_valid, change_coin};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got credit=%0d rej=%b short=%b vv=%b vid=%0d chv=%b chc=%0d, want credit=%0d rej=%b short=%b vv=%b vid=%0d chv=%b chc=%0d",
                     name, act[15:8], act[7], act[6], act[5], act[4:3], act[2], act[1:0],
                     exp[15:8], exp[7], exp[6], exp[5], exp[4:3], exp[2], exp[1:0]);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        coin_valid   = v.in_cv;
        coin_type    = v.in_ct;
        sel_valid    = v.in_sv;
        sel_id       = v.in_sid;
        cancel       = v.in_can;
        vend_ready   = v.in_vr;
        change_ready = v.in_cr;
    endtask

    task automatic run_vec(input vec_t v, input string name);
        @(negedge clk);
        drive(v);
        @(posedge clk);
        #1;
        check(name, act_of(), exp_of(v));
    endtask

    initial begin
        vec_t idle_v;
        int   n;
        idle_v = mk(0,0,0,0,0,0,0, 0,0,0,0,0,0,0);

        // A: 50+50+20, buy product 0 (120), no change
        vecs.push_back(mk(1,2,0,0,0,0,0,  50,0,0,0,0,0,0));
        vecs.push_back(mk(1,2,0,0,0,0,0, 100,0,0,0,0,0,0));
        vecs.push_back(mk(1,1,0,0,0,0,0, 120,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,1,0,0,0,0, 120,0,0,1,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,1,0,   0,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,   0,0,0,0,0,0,0));
        // B: 100+50, buy product 3 (50), change 100
        vecs.push_back(mk(1,3,0,0,0,0,0, 100,0,0,0,0,0,0));
        vecs.push_back(mk(1,2,0,0,0,0,0, 150,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,1,3,0,0,0, 150,0,0,1,3,0,0));
        vecs.push_back(mk(0,0,0,0,0,1,0, 100,0,0,0,3,1,3));
        vecs.push_back(mk(0,0,0,0,0,0,1,   0,0,0,0,3,0,0));
        // C: 20, product 1 (90) too expensive, cancel refunds 20
        vecs.push_back(mk(1,1,0,0,0,0,0,  20,0,0,0,3,0,0));
        vecs.push_back(mk(0,0,1,1,0,0,0,  20,0,1,0,3,0,0));
        vecs.push_back(mk(0,0,0,0,1,0,0,  20,0,0,0,3,1,1));
        vecs.push_back(mk(0,0,0,0,0,0,0,  20,0,0,0,3,1,1));
        vecs.push_back(mk(0,0,0,0,0,0,1,   0,0,0,0,3,0,0));
        // D: fill to 250, 10 more overflows 255, then refund 100+100+50
        vecs.push_back(mk(1,3,0,0,0,0,0, 100,0,0,0,3,0,0));
        vecs.push_back(mk(1,3,0,0,0,0,0, 200,0,0,0,3,0,0));
        vecs.push_back(mk(1,1,0,0,0,0,0, 220,0,0,0,3,0,0));
        vecs.push_back(mk(1,1,0,0,0,0,0, 240,0,0,0,3,0,0));
        vecs.push_back(mk(1,0,0,0,0,0,0, 250,0,0,0,3,0,0));
        vecs.push_back(mk(1,0,0,0,0,0,0, 250,1,0,0,3,0,0));
        vecs.push_back(mk(0,0,0,0,1,0,0, 250,0,0,0,3,1,3));
        vecs.push_back(mk(0,0,0,0,0,0,1, 150,0,0,0,3,1,3));
        vecs.push_back(mk(0,0,0,0,0,0,1,  50,0,0,0,3,1,2));
        vecs.push_back(mk(0,0,0,0,0,0,1,   0,0,0,0,3,0,0));
        // E: coin+sel vends on pre-coin credit, coins rejected while VEND stalls 5 cycles
        vecs.push_back(mk(1,3,0,0,0,0,0, 100,0,0,0,3,0,0));
        vecs.push_back(mk(1,2,1,2,0,0,0, 100,1,0,1,2,0,0));
        vecs.push_back(mk(1,1,0,0,0,0,0, 100,1,0,1,2,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0, 100,0,0,1,2,0,0));
        vecs.push_back(mk(1,0,0,0,0,0,0, 100,1,0,1,2,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0, 100,0,0,1,2,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0, 100,0,0,1,2,0,0));
        vecs.push_back(mk(0,0,0,0,0,1,0,  30,0,0,0,2,1,1));
        vecs.push_back(mk(0,0,0,0,0,0,1,  10,0,0,0,2,1,0));
        vecs.push_back(mk(0,0,0,0,0,0,1,   0,0,0,0,2,0,0));
        // F: short sel keeps coin, cancel beats sel, idle cancel ignored, idle short
        vecs.push_back(mk(1,1,0,0,0,0,0,  20,0,0,0,2,0,0));
        vecs.push_back(mk(1,2,1,0,0,0,0,  70,0,1,0,2,0,0));
        vecs.push_back(mk(0,0,1,2,1,0,0,  70,0,0,0,2,1,2));
        vecs.push_back(mk(0,0,0,0,0,0,1,  20,0,0,0,2,1,1));
        vecs.push_back(mk(0,0,0,0,0,0,1,   0,0,0,0,2,0,0));
        vecs.push_back(mk(0,0,0,0,1,0,0,   0,0,0,0,2,0,0));
        vecs.push_back(mk(0,0,1,3,0,0,0,   0,0,1,0,2,0,0));

        rst_n = 1'b0;
        drive(idle_v);
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", act_of(), exp_of(idle_v));
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Asynchronous reset in the middle of a CHANGE payout
        run_vec(mk(1,3,0,0,0,0,0, 100,0,0,0,2,0,0), "rst_pre_coin");
        run_vec(mk(0,0,0,0,1,0,0, 100,0,0,0,2,1,3), "rst_pre_change");
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async", act_of(), exp_of(idle_v));
        @(negedge clk);
        rst_n = 1'b1;
        drive(mk(1,2,0,0,0,0,0, 0,0,0,0,0,0,0));
        @(posedge clk);
        #1;
        check("first_after_rst", act_of(), exp_of(mk(0,0,0,0,0,0,0, 50,0,0,0,0,0,0)));
        run_vec(mk(0,0,1,3,0,0,0, 50,0,0,1,3,0,0), "post_rst_vend");
        run_vec(mk(0,0,0,0,0,1,0,  0,0,0,0,3,0,0), "post_rst_done");

        // Inactivity with credit 70
        run_vec(mk(1,2,0,0,0,0,0, 50,0,0,0,3,0,0), "to_coin50");
        run_vec(mk(1,1,0,0,0,0,0, 70,0,0,0,3,0,0), "to_coin20");
        @(negedge clk);
        drive(idle_v);
`ifdef VM_CTRL_TIMEOUT_EN
        n = 0;
        while (change_valid !== 1'b1 && n < int'(TO) + 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_int("timeout_cycles", n, int'(TO));
        check("timeout_change", act_of(), exp_of(mk(0,0,0,0,0,0,0, 70,0,0,0,3,1,2)));
        run_vec(mk(0,0,0,0,0,0,1, 20,0,0,0,3,1,1), "timeout_pay50");
        run_vec(mk(0,0,0,0,0,0,1,  0,0,0,0,3,0,0), "timeout_pay20");
`else
        n = 0;
        repeat (TO + 10) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("no_timeout", act_of(), exp_of(mk(0,0,0,0,0,0,0, 70,0,0,0,3,0,0)));
        run_vec(mk(0,0,0,0,1,0,0, 70,0,0,0,3,1,2), "no_to_cancel");
        run_vec(mk(0,0,0,0,0,0,1, 20,0,0,0,3,1,1), "no_to_pay50");
        run_vec(mk(0,0,0,0,0,0,1,  0,0,0,0,3,0,0), "no_to_pay20");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
